// File: rtl/hamming_encoder_stream_if.sv
// Valid/ready stream bundle for the Hamming(16,11) encoder: payload and injection
// controls in, codewords out.
interface hamming_encoder_stream_if;
  logic        in_valid;
  logic [10:0] in_data;
  logic        in_ready;
  logic        inj_en;
  logic [15:0] inj_mask;
  logic        out_valid;
  logic [15:0] out_codeword;
  logic        out_ready;

  // master drives payloads and consumes codewords; slave is the encoder itself
  modport master (
    output in_valid, in_data, inj_en, inj_mask, out_ready,
    input  in_ready, out_valid, out_codeword
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_mask, out_ready,
    output in_ready, out_valid, out_codeword
  );
endinterface

// File: rtl/hamming_encoder_stream.sv
// Two-stage streaming SECDED Hamming(16,11) encoder with per-word error injection
// and a saturating delivered-word counter.
module hamming_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hamming_encoder_stream_if.slave bus,
  output logic [CNT_W-1:0]      word_count
);

  logic        s1_valid;
  logic [10:0] s1_data;
  logic [3:0]  s1_par;
  logic        s1_inj_en;
  logic [15:0] s1_inj_mask;

  logic        out_valid_q;
  logic [15:0] out_cw_q;

  logic        s2_adv;
  logic        s1_adv;
  logic        deliver;
  logic [3:0]  in_par;
  logic [15:1] cw_upper;
  logic [15:0] cw_clean;
  logic [15:0] cw_final;

  // s1_par holds {p8, p4, p2, p1}, i.e. the bits destined for cw[8], cw[4], cw[2], cw[1]
  always_comb begin
    in_par[0] = bus.in_data[0] ^ bus.in_data[1] ^ bus.in_data[3] ^ bus.in_data[4]
              ^ bus.in_data[6] ^ bus.in_data[8] ^ bus.in_data[10];
    in_par[1] = bus.in_data[0] ^ bus.in_data[2] ^ bus.in_data[3] ^ bus.in_data[5]
              ^ bus.in_data[6] ^ bus.in_data[9] ^ bus.in_data[10];
    in_par[2] = bus.in_data[1] ^ bus.in_data[2] ^ bus.in_data[3] ^ bus.in_data[7]
              ^ bus.in_data[8] ^ bus.in_data[9] ^ bus.in_data[10];
    in_par[3] = ^bus.in_data[10:4];
  end

  always_comb begin
    cw_upper = {s1_data[10:4], s1_par[3], s1_data[3:1], s1_par[2],
                s1_data[0], s1_par[1], s1_par[0]};
    cw_clean = {cw_upper, ^cw_upper};
    cw_final = s1_inj_en ? (cw_clean ^ s1_inj_mask) : cw_clean;
  end

  always_comb begin
    s2_adv  = !out_valid_q || bus.out_ready;
    s1_adv  = !s1_valid || s2_adv;
    deliver = out_valid_q && bus.out_ready;
  end

  assign bus.in_ready     = s1_adv;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_codeword = out_cw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_par      <= '0;
      s1_inj_en   <= 1'b0;
      s1_inj_mask <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data     <= bus.in_data;
        s1_par      <= in_par;
        s1_inj_en   <= bus.inj_en;
        s1_inj_mask <= bus.inj_mask;
      end
    end
  end

  // The codeword register only reloads on a real transfer so it stays stable under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_cw_q <= cw_final;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= '0;
    end else if (deliver && (word_count != '1)) begin
      word_count <= word_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Scoreboard bench for hamming_encoder_stream: a generic Hamming reference model
// predicts every codeword, and a reference decoder confirms payload recovery.
module tb_hamming_encoder_stream;

  typedef struct {
    logic [15:0] cw;
    logic        clean;
    logic [10:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] word_count;
  logic [1:0]  word_count2;

  int          checks;
  int          errors;
  int          cyc;
  int          delivered;
  int          or_mode;
  logic        or_fixed;
  logic        stall_prev;
  logic [15:0] stall_cw;

  exp_t        sb[$];
  int          deliv_cyc[$];
  logic [15:0] deliv_cw[$];

  hamming_encoder_stream_if bus ();
  hamming_encoder_stream_if bus2 ();

  hamming_encoder_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .word_count(word_count)
  );

  hamming_encoder_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .word_count(word_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready for the main DUT has a single driver: fixed level or a coin flip per cycle
  always @(posedge clk) begin
    #1;
    bus.out_ready = (or_mode != 0) ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Generic Hamming rule: data fills the non-power-of-two positions in order, parity at 2^k
  function automatic logic [15:0] ref_encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if (((pos >> p) & 1) == 1 && pos != (1 << p)) par ^= cw[pos];
      cw[1 << p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic void ref_decode(input logic [15:0] cw, output logic one,
                                     output logic two, output logic [10:0] msg);
    int          syn;
    int          k;
    logic [15:0] c;
    syn = 0;
    for (int i = 1; i < 16; i++) if (cw[i]) syn ^= i;
    one = ^cw;
    two = !one && (syn != 0);
    c = cw;
    if (one && syn != 0) c[syn] = ~c[syn];
    k = 0;
    msg = '0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        msg[k] = c[pos];
        k++;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) begin
      exp_t e;
      e.d     = bus.in_data;
      e.clean = !bus.inj_en || (bus.inj_mask == 16'h0000);
      e.cw    = ref_encode(bus.in_data) ^ (bus.inj_en ? bus.inj_mask : 16'h0000);
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.out_valid) checkOutput("stall_hold", bus.out_codeword, stall_cw);
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_cw   = bus.out_codeword;
      if (bus.out_valid && bus.out_ready) begin
        deliv_cyc.push_back(cyc);
        deliv_cw.push_back(bus.out_codeword);
        checkOutput("word_count", word_count, (delivered < 65535) ? delivered : 65535);
        delivered++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h expected none", bus.out_codeword);
        end else begin
          exp_t        e;
          logic        one;
          logic        two;
          logic [10:0] msg;
          e = sb.pop_front();
          checkOutput("codeword", bus.out_codeword, e.cw);
          if (e.clean) begin
            ref_decode(bus.out_codeword, one, two, msg);
            checkOutput("decode_clean", {one, two, 5'd0, msg}, {2'b00, 5'd0, e.d});
          end
        end
      end
    end
  end

  // Present one word (called #1 after a rising edge) and hold it until accepted
  task automatic applyStimulus(input logic [10:0] d, input logic en, input logic [15:0] mask);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.inj_en   = en;
    bus.inj_mask = mask;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 for data %0h", d);
    end
    bus.in_valid = 1'b0;
    bus.inj_en   = 1'($urandom_range(0, 1));
    bus.inj_mask = 16'($urandom);
    bus.in_data  = 11'($urandom);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 1000; i++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    if (i == 1000) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    logic [10:0] w[5];
    logic        one;
    logic        two;
    logic [10:0] msg;
    logic [15:0] held;
    int          c0;
    int          acc;
    int          n2;

    checks = 0; errors = 0; cyc = 0; delivered = 0;
    or_mode = 0; or_fixed = 1'b1; stall_prev = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.inj_en = 1'b0; bus.inj_mask = '0;
    bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.inj_en = 1'b0; bus2.inj_mask = '0;
    bus2.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_codeword", bus.out_codeword, 16'h0000);
    checkOutput("reset_word_count", word_count, 0);
    checkOutput("reset_in_ready", bus.in_ready, 1);

    // back-to-back known payloads
    c0 = cyc;
    deliv_cyc.delete();
    deliv_cw.delete();
    applyStimulus(11'h000, 1'b0, 16'h0000);
    applyStimulus(11'h001, 1'b0, 16'h0000);
    applyStimulus(11'h7FF, 1'b0, 16'h0000);
    drain();
    checkOutput("t1_count", deliv_cw.size(), 3);
    if (deliv_cw.size() >= 3) begin
      checkOutput("t1_cw0", deliv_cw[0], 16'h0000);
      checkOutput("t1_cw1", deliv_cw[1], 16'h000F);
      checkOutput("t1_cw2", deliv_cw[2], 16'hFFFF);
      checkOutput("t1_lat0", deliv_cyc[0], c0 + 2);
      checkOutput("t1_lat1", deliv_cyc[1], c0 + 3);
      checkOutput("t1_lat2", deliv_cyc[2], c0 + 4);
    end
    checkOutput("t1_word_count", word_count, 3);

    // error injection, captured per word
    deliv_cw.delete();
    applyStimulus(11'h001, 1'b1, 16'h0010);
    applyStimulus(11'h001, 1'b1, 16'h0011);
    applyStimulus(11'h001, 1'b1, 16'h0000);
    drain();
    checkOutput("inj_count", deliv_cw.size(), 3);
    if (deliv_cw.size() >= 3) begin
      checkOutput("inj_single_cw", deliv_cw[0], 16'h001F);
      ref_decode(deliv_cw[0], one, two, msg);
      checkOutput("inj_single_dec", {one, two, msg}, {2'b10, 11'h001});
      checkOutput("inj_double_cw", deliv_cw[1], 16'h001E);
      ref_decode(deliv_cw[1], one, two, msg);
      checkOutput("inj_double_dec", {one, two}, 2'b01);
      checkOutput("inj_zero_mask", deliv_cw[2], 16'h000F);
    end

    // backpressure: 5 words against a stalled sink
    for (int i = 0; i < 5; i++) w[i] = 11'($urandom);
    deliv_cw.delete();
    or_fixed = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = w[acc];
      bus.inj_en   = 1'b0;
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checkOutput("stall_accepted", acc, 2);
    checkOutput("stall_in_ready", bus.in_ready, 0);
    held = bus.out_codeword;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_cw_stable", bus.out_codeword, held);
    checkOutput("stall_cw_value", held, ref_encode(w[0]));
    or_fixed = 1'b1;
    for (int i = acc; i < 5; i++) applyStimulus(w[i], 1'b0, 16'h0000);
    drain();
    checkOutput("stall_delivered", deliv_cw.size(), 5);
    if (deliv_cw.size() >= 5)
      for (int i = 0; i < 5; i++) checkOutput("stall_order", deliv_cw[i], ref_encode(w[i]));

    // all payloads with random sink stalls and random source gaps
    or_mode = 1;
    for (int d = 0; d < 2048; d++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(11'(d), 1'b0, 16'($urandom));
    end
    for (int i = 0; i < 300; i++)
      applyStimulus(11'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
    or_mode = 0;
    @(posedge clk);
    #1;
    drain();
    checkOutput("bulk_word_count", word_count, delivered);

    // reset with two words in flight
    or_fixed = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(11'h123, 1'b0, 16'h0000);
    applyStimulus(11'h456, 1'b0, 16'h0000);
    #2;
    rst = 1'b1;
    sb.delete();
    delivered = 0;
    #1;
    checkOutput("async_rst_out_valid", bus.out_valid, 0);
    checkOutput("async_rst_word_count", word_count, 0);
    checkOutput("async_rst_codeword", bus.out_codeword, 16'h0000);
    or_fixed = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    deliv_cw.delete();
    @(negedge clk);
    checkOutput("post_rst_in_ready", bus.in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("no_stale_words", deliv_cw.size(), 0);
    checkOutput("post_rst_word_count", word_count, 0);

    // saturation of a 2-bit counter
    n2 = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) begin
      bus2.in_valid = (k < 5);
      bus2.in_data  = 11'($urandom);
      @(negedge clk);
      checkOutput("sat_word_count", word_count2, (n2 < 3) ? n2 : 3);
      if (bus2.out_valid && bus2.out_ready) n2++;
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    checkOutput("sat_delivered", n2, 5);
    checkOutput("sat_final", word_count2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
